dcache_line_adapter: RTL and testbench

DCACHE_LINE_ADAPTER -- requirements
Module: dcache_line_adapter

---
 rtl/dcache_line_adapter.sv | 132 +++++++++++++
 tb/tb_dcache_line_adapter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_adapter.sv
// rtl/dcache_line_adapter.sv - 256-bit dcache line to 4x64-bit burst memory adapter
module dcache_line_adapter #(
    parameter bit CHECK_RADDR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ_REQ  = 3'd2;
    localparam logic [2:0] S_READ_WAIT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [26:0]  addr_q, addr_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] rline_q, rline_d;
    logic         beat_ok;
    logic         unused_low_bits;

    // Line offset bits carry no meaning for a whole-line transfer.
    assign unused_low_bits = ^{dfp_addr[4:0], bmem_raddr[4:0]};

    // A read beat counts only when valid and, optionally, tagged with our line.
    always_comb begin
        beat_ok = bmem_rvalid;
        if (CHECK_RADDR && (bmem_raddr[31:5] != addr_q)) begin
            beat_ok = 1'b0;
        end
    end

    // Next-state, beat counter, latched request and fill-line assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            S_IDLE: begin
                if (dfp_write) begin
                    addr_d  = dfp_addr[31:5];
                    wline_d = dfp_wdata;
                    cnt_d   = 2'd0;
                    state_d = S_WRITE;
                end else if (dfp_read) begin
                    addr_d  = dfp_addr[31:5];
                    cnt_d   = 2'd0;
                    state_d = S_READ_REQ;
                end
            end
            S_WRITE: begin
                if (bmem_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ_REQ: begin
                if (bmem_ready) begin
                    state_d = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (beat_ok) begin
                    rline_d[{cnt_q, 6'd0} +: 64] = bmem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded purely from registered state so they hold during stalls.
    always_comb begin
        dfp_rdata  = rline_q;
        dfp_resp   = (state_q == S_DONE);
        bmem_read  = (state_q == S_READ_REQ);
        bmem_write = (state_q == S_WRITE);
        bmem_addr  = 32'd0;
        bmem_wdata = 64'd0;
        if ((state_q == S_WRITE) || (state_q == S_READ_REQ)) begin
            bmem_addr = {addr_q, 5'd0};
        end
        if (state_q == S_WRITE) begin
            bmem_wdata = wline_q[{cnt_q, 6'd0} +: 64];
        end
    end

    // State and datapath registers; reset aborts any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 27'd0;
            wline_q <= 256'd0;
            rline_q <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

endmodule

// File: tb/tb_dcache_line_adapter.sv
// tb/tb_dcache_line_adapter.sv - scoreboard bench for dcache_line_adapter
module tb_dcache_line_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int total = 0;
    int bad = 0;

    // Scoreboard: expected write beats {addr, data} and expected resp lines.
    logic [95:0]  exp_wq[$];
    logic [255:0] exp_rq[$];
    // Reference fill line: what dfp_rdata must show after the last completed read.
    logic [255:0] model_line;

    dcache_line_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: pops and compares whenever the DUT presents a beat or a response.
    always @(negedge clk) begin
        logic [95:0]  e;
        logic [255:0] l;
        if (rst === 1'b1) begin
            if (bmem_write && bmem_ready) begin
                if (exp_wq.size() == 0) begin
                    check("unexpected_wbeat", 1, 0);
                end else begin
                    e = exp_wq.pop_front();
                    check("wbeat_addr", bmem_addr, e[95:64]);
                    check("wbeat_data", bmem_wdata, e[63:0]);
                end
            end else if (bmem_write && exp_wq.size() != 0) begin
                e = exp_wq[0];
                check("wbeat_stall_hold", bmem_wdata, e[63:0]);
            end
            if (!bmem_write) check("wdata_idle_zero", bmem_wdata, 0);
            if (!bmem_write && !bmem_read) check("addr_idle_zero", bmem_addr, 0);
            if (dfp_resp) begin
                if (exp_rq.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    l = exp_rq.pop_front();
                    check("resp_rdata", dfp_rdata, l);
                end
            end
        end
    end

    // Starts in IDLE (#1 after an edge); ends #1 into the IDLE cycle after resp.
    task automatic write_phase(input logic [31:0] addr, input logic [255:0] line,
                               input int s0, input int s1, input int s2, input int s3);
        int st[4];
        st = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) exp_wq.push_back({addr[31:5], 5'd0, line[64*k +: 64]});
        exp_rq.push_back(model_line);
        dfp_write = 1'b1;
        dfp_addr  = addr;
        dfp_wdata = line;
        @(posedge clk); #1;
        dfp_addr  = $urandom;
        dfp_wdata = rnd256();
        for (int k = 0; k < 4; k++) begin
            bmem_ready = 1'b0;
            repeat (st[k]) begin
                @(posedge clk); #1;
            end
            bmem_ready = 1'b1;
            @(posedge clk); #1;
        end
        bmem_ready = 1'b0;
        check("write_resp_pulse", dfp_resp, 1);
        check("write_no_more_beats", bmem_write, 0);
        @(posedge clk); #1;
        check("write_resp_single", dfp_resp, 0);
        dfp_write = 1'b0;
    endtask

    // Read with a given request stall and per-beat gaps; stale beats fill gaps if enabled.
    task automatic read_phase(input logic [31:0] addr, input logic [255:0] line, input int req_stall,
                              input int g0, input int g1, input int g2, input int g3,
                              input bit stale_en, input int abort_after);
        int gp[4];
        gp = '{g0, g1, g2, g3};
        dfp_read = 1'b1;
        dfp_addr = addr;
        @(posedge clk); #1;
        dfp_addr  = $urandom;
        dfp_read  = 1'($urandom_range(0, 1));
        bmem_ready = 1'b0;
        for (int c = 0; c <= req_stall; c++) begin
            if (c == req_stall) bmem_ready = 1'b1;
            check("read_cmd_high", bmem_read, 1);
            check("read_cmd_addr", bmem_addr, {addr[31:5], 5'd0});
            @(posedge clk); #1;
        end
        bmem_ready = 1'b0;
        check("read_cmd_drop", bmem_read, 0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gp[k]; g++) begin
                bmem_rvalid = stale_en && ($urandom_range(0, 1) == 1);
                bmem_raddr  = addr ^ 32'h0000_1000;
                bmem_rdata  = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            if (k == abort_after) return;
            bmem_rvalid = 1'b1;
            bmem_raddr  = {addr[31:5], 5'($urandom)};
            bmem_rdata  = line[64*k +: 64];
            if (k == 3) begin
                model_line = line;
                exp_rq.push_back(line);
            end
            check("read_no_early_resp", dfp_resp, 0);
            @(posedge clk); #1;
        end
        bmem_rvalid = 1'b0;
        check("read_resp_pulse", dfp_resp, 1);
        @(posedge clk); #1;
        check("read_resp_single", dfp_resp, 0);
        dfp_read = 1'b0;
    endtask

    initial begin
        logic [255:0] line;
        rst = 1'b0;
        dfp_addr = 0; dfp_read = 0; dfp_write = 0; dfp_wdata = 0;
        bmem_ready = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
        model_line = 256'd0;
        #2;
        check("rst_resp", dfp_resp, 0);
        check("rst_rdata", dfp_rdata, 0);
        check("rst_bmem_read", bmem_read, 0);
        check("rst_bmem_write", bmem_write, 0);
        check("rst_bmem_addr", bmem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) line[64*k +: 64] = 64'hA0A0_0000_0000_0000 | 64'(k);
        write_phase(32'h0000_1040, line, 0, 0, 0, 0);
        write_phase(32'h0000_1040, rnd256(), 0, 3, 3, 0);

        line = {64'd4, 64'd3, 64'd2, 64'd1};
        read_phase(32'h0000_2000, line, 0, 0, 2, 0, 5, 1'b0, 4);
        read_phase(32'h0000_2000, rnd256(), 1, 1, 3, 2, 2, 1'b1, 4);
        write_phase(32'h0000_5000, rnd256(), 1, 0, 2, 0);
        check("rdata_unchanged_by_write", dfp_rdata, model_line);

        dfp_read = 1'b1;
        write_phase(32'h0000_6000, rnd256(), 0, 0, 0, 0);
        check("both_read_not_yet", bmem_read, 0);
        read_phase(32'h0000_7000, rnd256(), 0, 1, 0, 1, 0, 1'b0, 4);

        read_phase(32'h0000_8000, rnd256(), 0, 0, 1, 0, 0, 1'b0, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_bmem_read", bmem_read, 0);
        check("arst_bmem_addr", bmem_addr, 0);
        check("arst_rdata", dfp_rdata, 0);
        check("arst_resp", dfp_resp, 0);
        model_line = 256'd0;
        dfp_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_8000;
            bmem_rdata  = {$urandom, $urandom};
            @(posedge clk); #1;
            check("aborted_no_resp", dfp_resp, 0);
            check("aborted_idle", bmem_read, 0);
        end
        bmem_rvalid = 1'b0;
        check("aborted_rdata_zero", dfp_rdata, 0);
        read_phase(32'h0000_8000, rnd256(), 0, 0, 0, 0, 0, 1'b0, 4);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                write_phase(a, rnd256(), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                read_phase(a, rnd256(), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), 4);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("wbeat_queue_drained", 256'(exp_wq.size()), 0);
        check("resp_queue_drained", 256'(exp_rq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
